// File: rtl/seq_multiplier.sv
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Sequential unsigned shift-and-add multiplier. One partial
//             product is accumulated per clock; the product is complete
//             WIDTH cycles after a start request is accepted. Uses the same
//             go/done/busy handshake as the restoring divider so one
//             controller can drive either unit.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous reset, active-low
//             go   - start request, sampled only while idle
//             a    - multiplicand (WIDTH bits), captured when go accepted
//             b    - multiplier   (WIDTH bits), captured when go accepted
//             p    - product register (2*WIDTH bits), holds last result
//             done - one-cycle pulse, product valid on p
//             busy - high while a multiplication is in progress or done
//  Options  : `define SEQ_MULT_ZERO_SKIP_EN to finish in a single cycle
//             when either operand is zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               done,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // {hi, lo}: hi accumulates partial sums, lo starts as the multiplier and
  // is shifted out LSB-first while the product bits shift in from hi.
  logic [2*WIDTH-1:0]   acc_q,   acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q,     p_d;

  // hi + mcand, one bit wider so the carry is kept before the shift.
  logic [WIDTH:0]       sum;
  logic                 zero_hit;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_hit = (a == '0) || (b == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    count_d = count_q;
    p_d     = p_q;
    sum     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (zero_hit) begin
            p_d     = '0;
            state_d = S_DONE;
          end else begin
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
            count_d = CW'(WIDTH);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + ({(WIDTH+1){acc_q[0]}} & {1'b0, mcand_q});
        // Shift {carry, hi, lo} right by one: carry becomes the new hi MSB,
        // old hi LSB becomes the new lo MSB, old lo LSB is discarded.
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          p_d     = {sum, acc_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign p    = p_q;
  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire
